// File: rtl/i2c_apb_pkg.sv
// Shared constants for the I2C APB register file: register offsets,
// interrupt bit positions and the slave-error build option.
// Optional feature macro: I2C_APB_SLVERR_EN (PSLVERR signalling).
package i2c_apb_pkg;

  localparam logic [7:0] OFF_CON    = 8'h00;
  localparam logic [7:0] OFF_SE     = 8'h04;
  localparam logic [7:0] OFF_OWN    = 8'h08;
  localparam logic [7:0] OFF_COM    = 8'h0C;
  localparam logic [7:0] OFF_DATA   = 8'h10;
  localparam logic [7:0] OFF_IE     = 8'h14;
  localparam logic [7:0] OFF_ISR    = 8'h18;
  localparam logic [7:0] OFF_CLKDIV = 8'h1C;
  localparam logic [7:0] OFF_TADD   = 8'h20;
  localparam logic [7:0] OFF_FSTAT  = 8'h24;
  localparam logic [7:0] OFF_THR    = 8'h28;

  localparam int ISR_RX_OV   = 0;
  localparam int ISR_NACK    = 1;
  localparam int ISR_DONE    = 2;
  localparam int ISR_TX_LOW  = 3;
  localparam int ISR_RX_HIGH = 4;
  localparam int ISR_TX_OV   = 5;

  // Bits of ISR that are held until cleared by software.
  localparam logic [5:0] ISR_STICKY = 6'b100111;

`ifdef I2C_APB_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

endpackage

// File: rtl/i2c_apb_fifo_regs_if.sv
// APB slave bus bundle for the I2C register file.
interface i2c_apb_fifo_regs_if;
  import i2c_apb_pkg::*;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/i2c_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle; flush empties the FIFO and wins over a same-cycle push.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign count     = wptr_r - rptr_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rptr_r[AW-1:0]];

  // Pointer update; reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push_s) wptr_r <= wptr_r + (AW+1)'(1);
      if (do_pop_s)  rptr_r <= rptr_r + (AW+1)'(1);
    end
  end

  // Storage write; a flushed push never lands.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush && !rst) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_apb_fifo_regs.sv
// APB register file for the I2C controller with TX/RX FIFOs, sticky W1C
// interrupt status, threshold interrupts and 10-bit target addressing.
// Optional feature macro: I2C_APB_SLVERR_EN (PSLVERR on bad accesses).
module i2c_apb_fifo_regs
  import i2c_apb_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h1C,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CLKDIV_W   = 16
) (
  input  logic                pclk,
  input  logic                prst,
  i2c_apb_fifo_regs_if.slave  apb,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_pop,
  input  logic [7:0]          rx_data,
  input  logic                rx_push,
  input  logic                i_tx_busy,
  input  logic                i_rx_busy,
  input  logic                i_mrs,
  input  logic                i_nack,
  input  logic                i_done,
  output logic                cfg_ctx,
  output logic                cfg_crx,
  output logic                cfg_ms,
  output logic                cfg_en,
  output logic                cfg_rw,
  output logic                cfg_sp,
  output logic                cfg_rs,
  output logic [6:0]          cfg_own_add,
  output logic [9:0]          cfg_tadd,
  output logic                cfg_tadd10,
  output logic [CLKDIV_W-1:0] cfg_clkdiv,
  output logic                irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]          con_r;
  logic                en_r;
  logic [6:0]          own_r;
  logic [2:0]          com_r;
  logic [5:0]          ie_r;
  logic [5:0]          sticky_r;
  logic [CLKDIV_W-1:0] clkdiv_r;
  logic [9:0]          tadd_r;
  logic                tadd10_r;
  logic [7:0]          txthr_r;
  logic [7:0]          rxthr_r;
  logic                irq_r;

  logic [7:0]  off_s;
  logic        acc_s, wr_s, rd_s, dec_s;
  logic        dat_wr_s, dat_rd_s;
  logic        tx_push_s, rx_pop_s, tx_flush_s, rx_flush_s;
  logic        tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [AW:0] tx_count_s, rx_count_s;
  logic [7:0]  rx_head_s;
  logic [5:0]  isr_set_s, isr_clr_s, isr_v_s;
  logic [31:0] rd_mux_s;

  // A reset during an access turns it into a no-op undecoded transfer.
  assign off_s      = apb.paddr - BASE_ADDR;
  assign acc_s      = apb.psel & apb.penable & ~prst;
  assign wr_s       = acc_s & apb.pwrite;
  assign rd_s       = acc_s & ~apb.pwrite;
  assign dat_wr_s   = wr_s & (off_s == OFF_DATA);
  assign dat_rd_s   = rd_s & (off_s == OFF_DATA);
  assign tx_push_s  = dat_wr_s & ~tx_full_s;
  assign rx_pop_s   = dat_rd_s;
  assign tx_flush_s = wr_s & (off_s == OFF_CON) & apb.pwdata[3];
  assign rx_flush_s = wr_s & (off_s == OFF_CON) & apb.pwdata[4];

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(pclk), .rst(prst), .push(tx_push_s), .pop(tx_pop), .flush(tx_flush_s),
    .wdata(apb.pwdata[7:0]), .rdata(tx_data), .full(tx_full_s),
    .empty(tx_empty_s), .count(tx_count_s)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(pclk), .rst(prst), .push(rx_push), .pop(rx_pop_s), .flush(rx_flush_s),
    .wdata(rx_data), .rdata(rx_head_s), .full(rx_full_s),
    .empty(rx_empty_s), .count(rx_count_s)
  );

  // Interrupt status: sticky event bits plus live threshold levels.
  always_comb begin
    isr_set_s              = 6'h00;
    isr_set_s[ISR_RX_OV]   = rx_push & rx_full_s & ~rx_pop_s & ~rx_flush_s;
    isr_set_s[ISR_NACK]    = i_nack;
    isr_set_s[ISR_DONE]    = i_done;
    isr_set_s[ISR_TX_OV]   = dat_wr_s & tx_full_s;
    isr_clr_s              = (wr_s && off_s == OFF_ISR) ? (apb.pwdata[5:0] & ISR_STICKY) : 6'h00;
    isr_v_s                = sticky_r;
    isr_v_s[ISR_TX_LOW]    = (8'(tx_count_s) <= txthr_r);
    isr_v_s[ISR_RX_HIGH]   = (8'(rx_count_s) >= rxthr_r);
  end

  // Read-data mux and address decode for the current APB address.
  always_comb begin
    rd_mux_s = 32'h0;
    dec_s    = 1'b1;
    case (off_s)
      OFF_CON:    rd_mux_s = {29'd0, con_r};
      OFF_SE:     rd_mux_s = {28'd0, ~tx_full_s, ~rx_empty_s, i_tx_busy | i_rx_busy, en_r};
      OFF_OWN:    rd_mux_s = {25'd0, own_r};
      OFF_COM:    rd_mux_s = {29'd0, com_r};
      OFF_DATA:   rd_mux_s = rx_empty_s ? 32'h0 : {24'd0, rx_head_s};
      OFF_IE:     rd_mux_s = {26'd0, ie_r};
      OFF_ISR:    rd_mux_s = {26'd0, isr_v_s};
      OFF_CLKDIV: rd_mux_s = 32'(clkdiv_r);
      OFF_TADD:   rd_mux_s = {16'd0, tadd10_r, 5'd0, tadd_r};
      OFF_FSTAT:  rd_mux_s = {16'd0, 8'(rx_count_s), 8'(tx_count_s)};
      OFF_THR:    rd_mux_s = {16'd0, rxthr_r, txthr_r};
      default:    dec_s    = 1'b0;
    endcase
  end

  assign apb.prdata = (apb.psel && !prst) ? rd_mux_s : 32'h0;
  assign apb.pready = apb.psel;

`ifdef I2C_APB_SLVERR_EN
  assign apb.pslverr = acc_s & (~dec_s | (dat_wr_s & tx_full_s) | (dat_rd_s & rx_empty_s) |
                                (wr_s & (off_s == OFF_FSTAT)));
`else
  assign apb.pslverr = 1'b0;
`endif

  // Configuration register writes; a repeated start always drops COM.rs.
  always_ff @(posedge pclk) begin
    if (prst) begin
      con_r    <= 3'd0;
      en_r     <= 1'b0;
      own_r    <= 7'd0;
      com_r    <= 3'd0;
      ie_r     <= 6'd0;
      clkdiv_r <= '0;
      tadd_r   <= 10'd0;
      tadd10_r <= 1'b0;
      txthr_r  <= 8'd0;
      rxthr_r  <= 8'd0;
    end else begin
      if (wr_s) begin
        case (off_s)
          OFF_CON:    con_r    <= apb.pwdata[2:0];
          OFF_SE:     en_r     <= apb.pwdata[0];
          OFF_OWN:    own_r    <= apb.pwdata[6:0];
          OFF_COM:    com_r    <= apb.pwdata[2:0];
          OFF_IE:     ie_r     <= apb.pwdata[5:0];
          OFF_CLKDIV: clkdiv_r <= apb.pwdata[CLKDIV_W-1:0];
          OFF_TADD:   begin
                        tadd_r   <= apb.pwdata[9:0];
                        tadd10_r <= apb.pwdata[15];
                      end
          OFF_THR:    begin
                        txthr_r <= apb.pwdata[7:0];
                        rxthr_r <= apb.pwdata[15:8];
                      end
          default:    ;
        endcase
      end
      if (i_mrs) com_r[2] <= 1'b0;
    end
  end

  // Sticky status bits: a same-cycle event beats the W1C clear.
  always_ff @(posedge pclk) begin
    if (prst) sticky_r <= 6'h00;
    else      sticky_r <= (isr_set_s | (sticky_r & ~isr_clr_s)) & ISR_STICKY;
  end

  // Registered interrupt request.
  always_ff @(posedge pclk) begin
    if (prst) irq_r <= 1'b0;
    else      irq_r <= |(isr_v_s & ie_r);
  end

  assign irq         = irq_r;
  assign tx_valid    = ~tx_empty_s;
  assign cfg_ctx     = con_r[0];
  assign cfg_crx     = con_r[1];
  assign cfg_ms      = con_r[2];
  assign cfg_en      = en_r;
  assign cfg_rw      = com_r[0];
  assign cfg_sp      = com_r[1];
  assign cfg_rs      = com_r[2];
  assign cfg_own_add = own_r;
  assign cfg_tadd    = tadd_r;
  assign cfg_tadd10  = tadd10_r;
  assign cfg_clkdiv  = clkdiv_r;

endmodule
